// File: rtl/muldiv_unit_pkg.sv
// Shared types and funct3 codes for the iterative RV32M multiply/divide unit.
// No logic here; latency and backpressure are defined by the users of these types.
package muldiv_unit_pkg;

    localparam int ROB_W = 5;
    localparam int PHY_W = 6;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } MD_STATE_t;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [ROB_W-1:0] rob_id;
        logic [PHY_W-1:0] rd_phy;
        logic [PHY_W-1:0] rs1_phy;
        logic [PHY_W-1:0] rs2_phy;
    } RS_ENTRY_t;

    function automatic logic md_a_signed(input logic [2:0] f3);
        return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
               (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic md_b_signed(input logic [2:0] f3);
        return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_iter_core.sv
// Unsigned radix-2 shift-add multiplier / restoring divider, one bit per step.
// acc_nxt is the accumulator value after the current step; no backpressure, caller owns sequencing.
module muldiv_iter_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           div_mode,
    input  logic           step,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] acc_nxt
);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   m_q, m_d;
    logic           mode_q, mode_d;

    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           ge;

    always_comb begin
        sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
        shifted = {acc_q[2*W-1:W], acc_q[W-1]};
        diff    = shifted - {1'b0, m_q};
        ge      = (shifted >= {1'b0, m_q});
        if (mode_q) begin
            acc_nxt = {(ge ? diff[W-1:0] : shifted[W-1:0]), acc_q[W-2:0], ge};
        end else begin
            acc_nxt = {sum, acc_q[W-1:1]};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        mode_d = mode_q;
        if (start) begin
            acc_d  = {{W{1'b0}}, (div_mode ? op_a : op_b)};
            m_d    = div_mode ? op_b : op_a;
            mode_d = div_mode;
        end else if (step) begin
            acc_d  = acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            m_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: DATA_WIDTH+1 cycles via the core, 1 cycle for div-by-zero/overflow.
// busy_md blocks issue from acceptance until the result cycle; flush abandons work at any time.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = ROB_W,
    parameter int PHY_WIDTH  = PHY_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  RS_ENTRY_t             issue_instruction_md,
    input  logic                  issue_md_valid,
    output logic [PHY_WIDTH-1:0]  rs1_phy_md,
    output logic [PHY_WIDTH-1:0]  rs2_phy_md,
    input  logic [DATA_WIDTH-1:0] rs1_data_md,
    input  logic [DATA_WIDTH-1:0] rs2_data_md,
    output logic                  md_valid,
    output logic [DATA_WIDTH-1:0] md_output,
    output logic [ROB_WIDTH-1:0]  md_rob_id,
    output logic [PHY_WIDTH-1:0]  rd_phy_md,
    output logic                  busy_md
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    MD_STATE_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            f3_q, f3_d;
    logic                  neg_q, neg_d;
    logic [ROB_WIDTH-1:0]  rob_q, rob_d;
    logic [PHY_WIDTH-1:0]  rd_q, rd_d;
    logic [W-1:0]          out_q, out_d;
    logic [ROB_WIDTH-1:0]  out_rob_q, out_rob_d;
    logic [PHY_WIDTH-1:0]  out_rd_q, out_rd_d;

    logic [2:0]     f3;
    logic           accept, is_div, a_neg, b_neg, res_neg, div_zero, ovf, fast;
    logic [W-1:0]   a_mag, b_mag, fast_res;
    logic [2*W-1:0] acc_nxt, prod_s;
    logic [W-1:0]   mul_res, div_v, div_s, core_res;
    logic           unused_fields;

    assign rs1_phy_md    = PHY_WIDTH'(issue_instruction_md.rs1_phy);
    assign rs2_phy_md    = PHY_WIDTH'(issue_instruction_md.rs2_phy);
    assign unused_fields = ^{issue_instruction_md.opcode, issue_instruction_md.funct7};

    assign f3     = issue_instruction_md.funct3;
    assign accept = issue_md_valid && (state_q == IDLE) && !flush;
    assign is_div = f3[2];

    always_comb begin
        a_neg    = md_a_signed(f3) && rs1_data_md[W-1];
        b_neg    = md_b_signed(f3) && rs2_data_md[W-1];
        a_mag    = a_neg ? -rs1_data_md : rs1_data_md;
        b_mag    = b_neg ? -rs2_data_md : rs2_data_md;
        // remainder takes the dividend's sign, everything else the product of signs
        res_neg  = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (rs2_data_md == '0);
        ovf      = is_div && md_b_signed(f3) && (rs1_data_md == {1'b1, {(W-1){1'b0}}})
                   && (&rs2_data_md);
        fast     = div_zero || ovf;
        if (div_zero) begin
            fast_res = f3[1] ? rs1_data_md : {W{1'b1}};
        end else begin
            fast_res = f3[1] ? {W{1'b0}} : rs1_data_md;
        end
    end

    muldiv_iter_core #(.W(W)) u_core (
        .clk      (clk),
        .rst_n    (rst),
        .start    (accept && !fast),
        .div_mode (is_div),
        .step     (state_q == CALC),
        .op_a     (a_mag),
        .op_b     (b_mag),
        .acc_nxt  (acc_nxt)
    );

    // High-half results need the full-width product negated before selecting
    always_comb begin
        prod_s   = neg_q ? -acc_nxt : acc_nxt;
        mul_res  = (f3_q == MD_MUL) ? prod_s[W-1:0] : prod_s[2*W-1:W];
        div_v    = f3_q[1] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
        div_s    = neg_q ? -div_v : div_v;
        core_res = f3_q[2] ? div_s : mul_res;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        rob_d     = rob_q;
        rd_d      = rd_q;
        out_d     = out_q;
        out_rob_d = out_rob_q;
        out_rd_d  = out_rd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d  = f3;
                    neg_d = res_neg;
                    rob_d = ROB_WIDTH'(issue_instruction_md.rob_id);
                    rd_d  = PHY_WIDTH'(issue_instruction_md.rd_phy);
                    if (fast) begin
                        state_d   = DONE;
                        out_d     = fast_res;
                        out_rob_d = ROB_WIDTH'(issue_instruction_md.rob_id);
                        out_rd_d  = PHY_WIDTH'(issue_instruction_md.rd_phy);
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(DATA_WIDTH - 1);
                    end
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    if (!flush) begin
                        state_d   = DONE;
                        out_d     = core_res;
                        out_rob_d = rob_q;
                        out_rd_d  = rd_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            rob_q     <= '0;
            rd_q      <= '0;
            out_q     <= '0;
            out_rob_q <= '0;
            out_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            rob_q     <= rob_d;
            rd_q      <= rd_d;
            out_q     <= out_d;
            out_rob_q <= out_rob_d;
            out_rd_q  <= out_rd_d;
        end
    end

    assign md_valid  = (state_q == DONE) && !flush;
    assign md_output = out_q;
    assign md_rob_id = out_rob_q;
    assign rd_phy_md = out_rd_q;
    assign busy_md   = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: scoreboard of expected {result, tag, cycle} per issued op.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        issue_md_valid = 1'b0;
    RS_ENTRY_t   ins = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic [5:0]  rs1_phy_md, rs2_phy_md, rd_phy_md;
    logic        md_valid, busy_md;
    logic [31:0] md_output;
    logic [4:0]  md_rob_id;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rob;
        logic [5:0]  rd;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    muldiv_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .issue_instruction_md (ins),
        .issue_md_valid       (issue_md_valid),
        .rs1_phy_md           (rs1_phy_md),
        .rs2_phy_md           (rs2_phy_md),
        .rs1_data_md          (rs1_data),
        .rs2_data_md          (rs2_data),
        .md_valid             (md_valid),
        .md_output            (md_output),
        .md_rob_id            (md_rob_id),
        .rd_phy_md            (rd_phy_md),
        .busy_md              (busy_md)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb_ = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb_; return p[31:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb_; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb_; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rob, input logic [5:0] rd);
        ins.opcode  = 7'b0110011;
        ins.funct7  = 7'b0000001;
        ins.funct3  = f3;
        ins.rob_id  = rob;
        ins.rd_phy  = rd;
        ins.rs1_phy = 6'd1;
        ins.rs2_phy = 6'd2;
        rs1_data    = a;
        rs2_data    = b;
    endtask

    // Called just after a negedge; leaves the bench 1ns after the acceptance edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rob, input logic [5:0] rd, input logic [31:0] exp_d,
                         input bit push, output int t);
        exp_t e;
        drive(f3, a, b, rob, rd);
        issue_md_valid = 1'b1;
        t = cyc;
        if (push) begin
            e.d = exp_d; e.rob = rob; e.rd = rd; e.cyc = t + latency(f3, a, b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1 issue_md_valid = 1'b0;
    endtask

    // Observes only: waits up to budget negedges for a result pulse.
    task automatic collect(input int budget, output bit ok, output logic [31:0] d,
                           output logic [4:0] r, output logic [5:0] p, output int c);
        ok = 1'b0; d = 'x; r = 'x; p = 'x; c = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (md_valid === 1'b1) begin
                ok = 1'b1; d = md_output; r = md_rob_id; p = rd_phy_md; c = cyc;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if ({md_valid, md_output, md_rob_id, rd_phy_md, busy_md} !== 45'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b out=%h rob=%0d rd=%0d busy=%b, need all 0",
                     md_valid, md_output, md_rob_id, rd_phy_md, busy_md);
        end
        rst = 1'b1;
        @(negedge clk);
        ins.rs1_phy = 6'd12;
        ins.rs2_phy = 6'd45;
        #1;
        tests++;
        if ({rs1_phy_md, rs2_phy_md} !== {6'd12, 6'd45}) begin
            fails++;
            $display("FAIL rs_phy_comb: got %0d/%0d, need 12/45", rs1_phy_md, rs2_phy_md);
        end
        tests++;
        if (busy_md !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy: got %b, need 0", busy_md);
        end
    endtask

    task automatic test_mul;
        int t, busy_bad, c;
        bit got, ok;
        logic [31:0] d;
        logic [4:0] r;
        logic [5:0] p;
        exp_t e;
        busy_bad = 0; got = 0; d = '0; r = '0; p = '0; c = -1;
        @(negedge clk);
        issue(MD_MUL, 32'd7, -32'sd3, 5'd4, 6'd9, 32'hFFFF_FFEB, 1'b1, t);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k <= 33 && busy_md !== 1'b1) busy_bad++;
            if (k == 34 && busy_md !== 1'b0) busy_bad++;
            if (md_valid === 1'b1 && !got) begin
                got = 1; d = md_output; r = md_rob_id; p = rd_phy_md; c = cyc;
            end
            if (k == 5) begin drive(MD_DIVU, 32'd100, 32'd7, 5'd1, 6'd1); issue_md_valid = 1'b1; end
            if (k == 6) issue_md_valid = 1'b0;
        end
        e = sb.pop_front();
        tests++;
        if (!got || {d, r, p} !== {e.d, e.rob, e.rd}) begin
            fails++;
            $display("FAIL mul_result: got %h rob %0d rd %0d, need %h rob %0d rd %0d", d, r, p, e.d, e.rob, e.rd);
        end
        tests++;
        if (c !== e.cyc) begin
            fails++;
            $display("FAIL mul_latency: got cycle %0d, need %0d", c, e.cyc);
        end
        tests++;
        if (busy_bad !== 0) begin
            fails++;
            $display("FAIL mul_busy_window: got %0d bad cycles, need 0", busy_bad);
        end
        collect(40, ok, d, r, p, c);
        tests++;
        if (ok) begin
            fails++;
            $display("FAIL busy_issue_ignored: got extra result %h at %0d, need none", d, c);
        end
    endtask

    task automatic test_table(input string name, input int n, input logic [2:0] f3s[6],
                              input logic [31:0] as[6], input logic [31:0] bs[6], input logic [31:0] exps[6]);
        int t, c;
        bit ok;
        logic [31:0] d;
        logic [4:0] r;
        logic [5:0] p;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issue(f3s[i], as[i], bs[i], 5'(i + 10), 6'(i + 20), exps[i], 1'b1, t);
            collect(40, ok, d, r, p, c);
            e = sb.pop_front();
            tests++;
            if (!ok || {d, r, p} !== {e.d, e.rob, e.rd}) begin
                fails++;
                $display("FAIL %s[%0d]: got %h rob %0d rd %0d, need %h rob %0d rd %0d",
                         name, i, d, r, p, e.d, e.rob, e.rd);
            end
            tests++;
            if (c !== e.cyc) begin
                fails++;
                $display("FAIL %s_latency[%0d]: got cycle %0d, need %0d", name, i, c, e.cyc);
            end
        end
    endtask

    task automatic test_mulh;
        logic [2:0]  f[6] = '{MD_MULH, MD_MULHSU, MD_MULHU, MD_MUL, MD_MUL, MD_MUL};
        logic [31:0] a[6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0};
        logic [31:0] b[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0};
        logic [31:0] x[6] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0};
        test_table("mulh", 3, f, a, b, x);
    endtask

    task automatic test_div;
        logic [2:0]  f[6] = '{MD_DIV, MD_REM, MD_DIVU, MD_MUL, MD_MUL, MD_MUL};
        logic [31:0] a[6] = '{-32'sd7, -32'sd7, 32'hFFFF_FFFE, 0, 0, 0};
        logic [31:0] b[6] = '{32'd2, 32'd2, 32'd2, 0, 0, 0};
        logic [31:0] x[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0};
        test_table("div", 3, f, a, b, x);
    endtask

    task automatic test_fast;
        logic [2:0]  f[6] = '{MD_DIV, MD_REMU, MD_DIV, MD_REM, MD_MUL, MD_MUL};
        logic [31:0] a[6] = '{32'd5, 32'd13, 32'h8000_0000, 32'h8000_0000, 0, 0};
        logic [31:0] b[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
        logic [31:0] x[6] = '{32'hFFFF_FFFF, 32'd13, 32'h8000_0000, 32'd0, 0, 0};
        test_table("fast", 4, f, a, b, x);
    endtask

    task automatic test_random;
        logic [2:0]  f[6];
        logic [31:0] a[6], b[6], x[6];
        for (int i = 0; i < 6; i++) begin
            f[i] = 3'($urandom_range(0, 7));
            a[i] = $urandom;
            b[i] = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i == 4) a[i] = -a[i] | 32'h8000_0000;
            x[i] = model(f[i], a[i], b[i]);
        end
        test_table("random", 6, f, a, b, x);
    endtask

    task automatic test_flush;
        int t, t2, c;
        bit ok;
        logic [31:0] d;
        logic [4:0] r;
        logic [5:0] p;
        exp_t e;
        @(negedge clk);
        issue(MD_DIV, 32'd1000, 32'd7, 5'd3, 6'd3, 32'd0, 1'b0, t);
        for (int i = 0; i < 20 && cyc != t + 10; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (busy_md !== 1'b0 || md_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: got busy=%b valid=%b at cycle %0d, need 0/0", busy_md, md_valid, cyc - t);
        end
        issue(MD_MUL, 32'd3, 32'd5, 5'd7, 6'd11, 32'd15, 1'b1, t2);
        collect(60, ok, d, r, p, c);
        e = sb.pop_front();
        tests++;
        if (!ok || {d, r, p} !== {e.d, e.rob, e.rd} || c !== t + 44) begin
            fails++;
            $display("FAIL flush_next_mul: got %h rob %0d rd %0d cycle T+%0d, need %h rob %0d rd %0d cycle T+44",
                     d, r, p, c - t, e.d, e.rob, e.rd);
        end
        // flush coincident with a DONE cycle, and with a new issue
        @(negedge clk);
        issue(MD_DIVU, 32'd9, 32'd0, 5'd5, 6'd5, 32'd0, 1'b0, t);
        @(negedge clk);
        flush = 1'b1;
        drive(MD_MUL, 32'd2, 32'd2, 5'd6, 6'd6);
        issue_md_valid = 1'b1;
        #1;
        tests++;
        if (md_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_done_suppress: got valid=%b, need 0", md_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        issue_md_valid = 1'b0;
        tests++;
        if (busy_md !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_issue: got busy=%b, need 0", busy_md);
        end
    endtask

    task automatic test_reset_mid;
        int t, c;
        bit ok;
        logic [31:0] d;
        logic [4:0] r;
        logic [5:0] p;
        exp_t e;
        exp_t e2;
        @(negedge clk);
        issue(MD_MUL, 32'd100, 32'd200, 5'd8, 6'd8, 32'd0, 1'b0, t);
        for (int i = 0; i < 20 && cyc != t + 5; i++) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({md_valid, md_output, md_rob_id, rd_phy_md, busy_md} !== 45'd0) begin
            fails++;
            $display("FAIL reset_mid: got v=%b out=%h rob=%0d rd=%0d busy=%b, need all 0",
                     md_valid, md_output, md_rob_id, rd_phy_md, busy_md);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(MD_MUL, 32'd6, 32'd7, 5'd2, 6'd3);
        issue_md_valid = 1'b1;
        t = cyc;
        e.d = 32'd42; e.rob = 5'd2; e.rd = 6'd3; e.cyc = t + 33;
        sb.push_back(e);
        e.cyc = t + 67;
        sb.push_back(e);
        for (int k = 0; k < 2; k++) begin
            collect(40, ok, d, r, p, c);
            e2 = sb.pop_front();
            tests++;
            if (!ok || {d, r, p} !== {e2.d, e2.rob, e2.rd} || c !== e2.cyc) begin
                fails++;
                $display("FAIL held_issue[%0d]: got %h rob %0d rd %0d cycle %0d, need %h rob %0d rd %0d cycle %0d",
                         k, d, r, p, c, e2.d, e2.rob, e2.rd, e2.cyc);
            end
        end
        issue_md_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast();
        test_random();
        test_flush();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit, parametrised in operand width, sitting beside the ALU, load/store and branch units in the execute stage. It accepts one `RS_ENTRY_t` from a dedicated issue port and reads its operands from the physical register file in the issue cycle. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles and returns a tagged result (ROB id, destination physical register) as a one-cycle pulse. While it works it raises `busy_md` so issue stalls, and it abandons work on `flush`.

## Interface
- `DATA_WIDTH`, 32, operand/result width (even, ≥8)
- `ROB_WIDTH`, 5, ROB id width
- `PHY_WIDTH`, 6, physical register index width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  pipeline flush (mispredict)
- `issue_instruction_md`  in  RS_ENTRY_t  issued entry; uses `funct3`, `rob_id`, `rd_phy`, `rs1_phy`, `rs2_phy`
- `issue_md_valid`  in  1  issue request
- `rs1_phy_md`, `rs2_phy_md`  out  PHY_WIDTH  combinational copies of the entry's rs1/rs2 physical indices
- `rs1_data_md`, `rs2_data_md`  in  DATA_WIDTH  register-file read data, same cycle as issue
- `md_valid`  out  1  result pulse
- `md_output`  out  DATA_WIDTH  result
- `md_rob_id`  out  ROB_WIDTH  result ROB id
- `rd_phy_md`  out  PHY_WIDTH  result destination
- `busy_md`  out  1  unit cannot accept issue

## Operation
- The issue request is accepted when `issue_md_valid && state==IDLE && !flush`. On acceptance the unit latches `funct3`, `rob_id`, `rd_phy` and both operands.
- `funct3` selects the operation:
  - 000 MUL: low half of the signed×signed product.
  - 001 MULH: high half of signed×signed.
  - 010 MULHSU: high half of signed×unsigned.
  - 011 MULHU: high half of unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Signed operations convert operands to magnitudes and record the result sign. The core is unsigned. The final negation is applied in the DONE transition.
- Multiply uses radix-2 shift-add into a 2·DATA_WIDTH accumulator, one multiplier bit per cycle.
- Divide uses radix-2 restoring division, one quotient bit per cycle.
  - Quotient sign is sign(a) XOR sign(b).
  - Remainder sign follows the dividend.
- Special cases are resolved at acceptance and skip the core (fast path):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (MIN / −1): DIV returns MIN; REM returns 0.
- State machine:
  - IDLE→CALC on acceptance; IDLE→DONE on acceptance via the fast path.
  - CALC counts `cnt` from DATA_WIDTH−1 down to 0, then →DONE.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `flush`.
- `md_valid = (state==DONE) && !flush`. `md_output`, `md_rob_id` and `rd_phy_md` are registers loaded on entry to DONE and held until the next DONE.
- `busy_md = (state != IDLE)`.
- The unit ignores `opcode` and `funct7`. Dispatch routes only OP/funct7=0000001 here.

## Timing
- Reset (`rst` low, asynchronous): state=IDLE, `cnt`=0, `md_valid`=0, `md_output`=0, `md_rob_id`=0, `rd_phy_md`=0, `busy_md`=0, all internal operand/accumulator registers 0.
- Acceptance in cycle T. The core path has `md_valid` high in cycle T+DATA_WIDTH+1, i.e. cycle 33 for the default width. The fast path has `md_valid` high in T+1.
- `busy_md` is high from T+1 through the DONE cycle inclusive. The earliest next acceptance is the cycle after DONE: T+DATA_WIDTH+2, or T+2 for the fast path.
- `issue_md_valid` while busy: the request is ignored. The issue stage must hold the request, since `busy_md` already blocks it.
- `flush` in any cycle:
  - The next state is IDLE.
  - A coincident issue is not accepted.
  - A coincident DONE cycle produces no `md_valid`.
- Reset asserted mid-operation aborts immediately with no result pulse after release.
- `rs*_phy_md` are purely combinational from `issue_instruction_md`, regardless of the valid signal.

## Structure
- Add constants `MD_MUL`…`MD_REMU` (3-bit funct3 codes) and the state enum `MD_STATE_t` {IDLE, CALC, DONE} to `parameter_pkg`/`typedef_pkg`.
- `RS_ENTRY_t` comes unchanged from `typedef_pkg`.
- One sub-module, `muldiv_iter_core`. It holds the unsigned shift-add/restoring datapath with start, mode and step inputs, and outputs the 2·DATA_WIDTH product or the quotient/remainder.
- The top level holds the FSM, sign handling, special-case detection, tag registers and flush logic.

## Test plan
- MUL 7×−3 (rob 4, rd 9) → `md_valid` exactly at T+33, `md_output`=0xFFFFFFEB, `md_rob_id`=4, `rd_phy_md`=9; `busy_md` high T+1..T+33.
- MULH/MULHSU/MULHU on 0x80000000×0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV −7/2 → −3 (0xFFFFFFFD); REM −7/2 → −1; DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF.
- DIV x/0 → 0xFFFFFFFF; REMU 13/0 → 13; DIV 0x80000000/−1 → 0x80000000. All `md_valid` at T+1.
- Flush at T+10 of a DIV → no `md_valid` ever for it; `busy_md` low at T+11; a new MUL 3×5 issued at T+11 → 15 at T+44.
- `rst` low at T+5 mid-MUL → all outputs 0 immediately; after release, `issue_md_valid` held during busy is accepted only in the cycle after DONE.
